// File: rtl/mem_pkg.sv
// Shared packet-memory geometry used by the read and write schedulers.
package mem_pkg;
  localparam int unsigned ADDR_W     = 12;
  localparam int unsigned BLOCK_BITS = 64;
endpackage

// File: rtl/mem_rd_scheduler_if.sv
// Requester-side and memory-side signal bundle for the packet-memory read scheduler.
interface mem_rd_scheduler_if #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
  parameter int unsigned BLOCK_BITS = mem_pkg::BLOCK_BITS
) ();
  logic [NUM_PORTS-1:0]             rd_req_i;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr_i;
  logic [NUM_PORTS-1:0]             rd_last_i;
  logic [NUM_PORTS-1:0]             rd_gnt_o;
  logic                             mem_re_o;
  logic [ADDR_W-1:0]                mem_raddr_o;
  logic [BLOCK_BITS-1:0]            mem_rdata_i;
  logic [NUM_PORTS-1:0]             rd_valid_o;
  logic [BLOCK_BITS-1:0]            rd_data_o;
  logic                             locked_o;

  modport slave (
    input  rd_req_i, rd_addr_i, rd_last_i, mem_rdata_i,
    output rd_gnt_o, mem_re_o, mem_raddr_o, rd_valid_o, rd_data_o, locked_o
  );

  modport master (
    output rd_req_i, rd_addr_i, rd_last_i, mem_rdata_i,
    input  rd_gnt_o, mem_re_o, mem_raddr_o, rd_valid_o, rd_data_o, locked_o
  );
endinterface

// File: rtl/mem_rd_scheduler.sv
// Round-robin sharing of the packet-memory read port among TX controllers, with
// burst locking and latency-matched steering of returned blocks.
module mem_rd_scheduler #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned ADDR_W     = mem_pkg::ADDR_W,
  parameter int unsigned BLOCK_BITS = mem_pkg::BLOCK_BITS
) (
  input logic               clk,
  input logic               rst,
  mem_rd_scheduler_if.slave bus
);
  localparam int unsigned   PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned   PIPE_W    = RD_LAT * PW;
  localparam logic [PW-1:0] LAST_PORT = PW'(NUM_PORTS - 1);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                      state_q, state_d;
  logic [PW-1:0]               ptr_q, ptr_d;
  logic [PW-1:0]               owner_q, owner_d;
  logic [RD_LAT-1:0]           pv_q, pv_d;
  logic [RD_LAT-1:0][PW-1:0]   pp_q, pp_d;

  logic                        issue_c;
  logic [PW-1:0]               sel_c;
  int unsigned                 idx_c;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == LAST_PORT) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      pv_q    <= '0;
      pp_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      pv_q    <= pv_d;
      pp_q    <= pp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    issue_c = 1'b0;
    sel_c   = owner_q;
    idx_c   = 0;

    unique case (state_q)
      IDLE: begin
        // First requester at or after ptr, wrapping by compare rather than modulo.
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
          idx_c = 32'(ptr_q) + i;
          if (idx_c >= NUM_PORTS) idx_c = idx_c - NUM_PORTS;
          if (!issue_c && bus.rd_req_i[PW'(idx_c)]) begin
            issue_c = 1'b1;
            sel_c   = PW'(idx_c);
          end
        end
        if (issue_c) begin
          if (bus.rd_last_i[sel_c]) begin
            ptr_d = wrap_inc(sel_c);
          end else begin
            state_d = LOCKED;
            owner_d = sel_c;
          end
        end
      end
      LOCKED: begin
        // Owner dropping its request leaves a bubble; the lock is kept.
        if (bus.rd_req_i[owner_q]) begin
          issue_c = 1'b1;
          if (bus.rd_last_i[owner_q]) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rst) issue_c = 1'b0;

    pv_d = RD_LAT'({pv_q, issue_c});
    pp_d = PIPE_W'({pp_q, sel_c});
  end

  assign bus.rd_gnt_o    = issue_c ? (NUM_PORTS'(1) << sel_c) : '0;
  assign bus.mem_re_o    = issue_c;
  assign bus.mem_raddr_o = issue_c ? bus.rd_addr_i[sel_c] : '0;
  assign bus.rd_valid_o  = (pv_q[RD_LAT-1] && !rst) ? (NUM_PORTS'(1) << pp_q[RD_LAT-1]) : '0;
  assign bus.rd_data_o   = bus.mem_rdata_i;
  assign bus.locked_o    = (state_q == LOCKED);

endmodule

// File: tb/tb_mem_rd_scheduler.sv
// Random-traffic bench for mem_rd_scheduler: a 4-port/latency-2 and a 3-port/latency-3
// instance run side by side against a transaction-level arbitration model.
module tb_mem_rd_scheduler;
  import mem_pkg::*;

  localparam int unsigned AW = ADDR_W;
  localparam int unsigned BW = BLOCK_BITS;
  localparam int          NCYC = 3000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]          req_v   [2];
  logic [3:0][AW-1:0]  addr_v  [2];
  logic [3:0]          last_v  [2];
  logic [BW-1:0]       rdata_v [2];

  logic [3:0]          gnt_o   [2];
  logic [3:0]          valid_o [2];
  logic                re_o    [2];
  logic                lk_o    [2];
  logic [AW-1:0]       raddr_o [2];
  logic [BW-1:0]       data_o  [2];

  mem_rd_scheduler_if #(.NUM_PORTS(4)) bus4 ();
  mem_rd_scheduler_if #(.NUM_PORTS(3)) bus3 ();

  assign bus4.rd_req_i    = req_v[0];
  assign bus4.rd_addr_i   = addr_v[0];
  assign bus4.rd_last_i   = last_v[0];
  assign bus4.mem_rdata_i = rdata_v[0];
  assign bus3.rd_req_i    = req_v[1][2:0];
  assign bus3.rd_addr_i   = addr_v[1][2:0];
  assign bus3.rd_last_i   = last_v[1][2:0];
  assign bus3.mem_rdata_i = rdata_v[1];

  assign gnt_o[0]   = bus4.rd_gnt_o;
  assign gnt_o[1]   = {1'b0, bus3.rd_gnt_o};
  assign valid_o[0] = bus4.rd_valid_o;
  assign valid_o[1] = {1'b0, bus3.rd_valid_o};
  assign re_o[0]    = bus4.mem_re_o;
  assign re_o[1]    = bus3.mem_re_o;
  assign lk_o[0]    = bus4.locked_o;
  assign lk_o[1]    = bus3.locked_o;
  assign raddr_o[0] = bus4.mem_raddr_o;
  assign raddr_o[1] = bus3.mem_raddr_o;
  assign data_o[0]  = bus4.rd_data_o;
  assign data_o[1]  = bus3.rd_data_o;

  mem_rd_scheduler #(.NUM_PORTS(4), .RD_LAT(2)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  mem_rd_scheduler #(.NUM_PORTS(3), .RD_LAT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int np_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  // Reference model: arbitration state and per-cycle issue history (-1 = no read).
  bit  m_locked [2];
  int  m_owner  [2];
  int  m_ptr    [2];
  int  hist     [2][8];

  // Requester behaviour: bursts of 1..4 beats, request held until granted.
  int            beats    [2][4];
  bit            req_on   [2][4];
  logic [AW-1:0] cur_addr [2][4];

  task automatic model_reset(input int k);
    m_locked[k] = 1'b0;
    m_owner[k]  = 0;
    m_ptr[k]    = 0;
    for (int i = 0; i < 8; i++) hist[k][i] = -1;
  endtask

  task automatic model_step(input int k, output int g);
    int np;
    int p;
    np = np_of(k);
    g  = -1;
    if (m_locked[k]) begin
      if (req_v[k][m_owner[k]]) g = m_owner[k];
    end else begin
      for (int i = 0; i < np; i++) begin
        p = (m_ptr[k] + i) % np;
        if (g < 0 && req_v[k][p]) g = p;
      end
    end
    if (g >= 0) begin
      if (last_v[k][g]) begin
        m_locked[k] = 1'b0;
        m_ptr[k]    = (g + 1) % np;
      end else begin
        m_locked[k] = 1'b1;
        m_owner[k]  = g;
      end
    end
  endtask

  task automatic drive_inputs(input int k);
    for (int p = 0; p < 4; p++) begin
      req_v[k][p]  = (p < np_of(k)) ? req_on[k][p] : 1'b0;
      addr_v[k][p] = cur_addr[k][p];
      last_v[k][p] = (beats[k][p] == 1);
    end
    rdata_v[k] = {$urandom, $urandom};
  endtask

  initial begin
    int  g;
    int  vp;
    bit  exp_lk;
    bit  in_rst;
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      for (int p = 0; p < 4; p++) begin
        beats[k][p]    = 0;
        req_on[k][p]   = 1'b0;
        cur_addr[k][p] = '0;
      end
      drive_inputs(k);
    end

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      in_rst = (c < 2) || ((c % 500) >= 498);
      if (in_rst) begin
        // Hold requests on the first and last port so reset gating and ptr=0 are exercised.
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
          model_reset(k);
          for (int p = 0; p < 4; p++) begin
            req_on[k][p]   = (p == 0) || (p == np_of(k) - 1);
            beats[k][p]    = req_on[k][p] ? 1 : 0;
            cur_addr[k][p] = AW'($urandom);
          end
          drive_inputs(k);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
          check_eq($sformatf("rst_gnt%0d", k),   64'(gnt_o[k]),   64'd0);
          check_eq($sformatf("rst_re%0d", k),    64'(re_o[k]),    64'd0);
          check_eq($sformatf("rst_raddr%0d", k), 64'(raddr_o[k]), 64'd0);
          check_eq($sformatf("rst_valid%0d", k), 64'(valid_o[k]), 64'd0);
          check_eq($sformatf("rst_lock%0d", k),  64'(lk_o[k]),    64'd0);
        end
      end else begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
          for (int p = 0; p < np_of(k); p++) begin
            if (!req_on[k][p]) begin
              if (beats[k][p] == 0 && $urandom_range(0, 3) == 0)
                beats[k][p] = int'($urandom_range(1, 4));
              if (beats[k][p] > 0 && $urandom_range(0, 3) != 0) begin
                req_on[k][p]   = 1'b1;
                cur_addr[k][p] = AW'($urandom);
              end
            end
          end
          drive_inputs(k);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
          exp_lk = m_locked[k];
          vp     = hist[k][(c - lat_of(k)) & 7];
          model_step(k, g);
          hist[k][c & 7] = g;
          check_eq($sformatf("gnt%0d", k),   64'(gnt_o[k]),   (g >= 0) ? (64'd1 << g) : 64'd0);
          check_eq($sformatf("re%0d", k),    64'(re_o[k]),    (g >= 0) ? 64'd1 : 64'd0);
          check_eq($sformatf("raddr%0d", k), 64'(raddr_o[k]), (g >= 0) ? 64'(addr_v[k][g]) : 64'd0);
          check_eq($sformatf("lock%0d", k),  64'(lk_o[k]),    64'(exp_lk));
          check_eq($sformatf("valid%0d", k), 64'(valid_o[k]), (vp >= 0) ? (64'd1 << vp) : 64'd0);
          check_eq($sformatf("data%0d", k),  64'(data_o[k]),  64'(rdata_v[k]));
          if (g >= 0) begin
            req_on[k][g] = 1'b0;
            beats[k][g]  = beats[k][g] - 1;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
